sa_input_skew: RTL and testbench

Upstream feeder for the systolic array's west edge. It accepts one activation vector per beat (one signed 8-bit element per array row) over a valid/ready handshake. It delays row r by r cycles to form the diagonal wavefront the PE grid requires, and drives each row's input, valid and weight-switch wires. It also tracks tile boundaries, holds off the producer while the last vector of a tile drains through the skew, and reports tile completion and tile length.

---
 rtl/sa_input_skew.sv | 124 ++++++++++++
 tb/tb_sa_input_skew.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sa_input_skew.sv
// rtl/sa_input_skew.sv - west-edge skew feeder for the systolic array
// Row r delays each accepted vector element by r cycles; also tracks tile boundaries.
module sa_input_skew #(
  parameter int ROWS  = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROWS*8-1:0]   in_data,
  input  logic                in_switch,
  input  logic                in_last,
  output logic [ROWS*8-1:0]   out_input,
  output logic [ROWS-1:0]     out_valid,
  output logic [ROWS-1:0]     out_switch,
  output logic                tile_done,
  output logic [CNT_W-1:0]    tile_len
);

  localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]  tile_len_q, tile_len_d;
  logic              tile_done_q, tile_done_d;
  logic              accept;

  assign in_ready = ~rst & (state_q != DRAIN);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    tile_len_d  = tile_len_q;
    case (state_q)
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q - DW'(1);
        end
      end
      default: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (in_last) begin
            state_d     = DRAIN;
            drain_cnt_d = DW'(ROWS - 1);
            tile_len_d  = beat_cnt_q + CNT_W'(1);
          end else begin
            state_d = STREAM;
          end
        end
      end
    endcase
    // Pulse lands in the same cycle the last beat reaches the bottom row.
    tile_done_d = (state_d == DRAIN) && (drain_cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      beat_cnt_q  <= '0;
      tile_len_q  <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      tile_len_q  <= tile_len_d;
      tile_done_q <= tile_done_d;
    end
  end

  assign tile_done = tile_done_q;
  assign tile_len  = tile_len_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [7:0] data_q [0:r];
    logic [7:0] data_d [0:r];
    logic [r:0] valid_q, valid_d;
    logic [r:0] switch_q, switch_d;

    // Bubbles carry zero data so idle array wires never show stale values.
    always_comb begin
      data_d[0]   = accept ? in_data[8*r +: 8] : 8'd0;
      valid_d[0]  = accept;
      switch_d[0] = accept & in_switch;
      for (int k = 1; k <= r; k++) begin
        data_d[k]   = data_q[k-1];
        valid_d[k]  = valid_q[k-1];
        switch_d[k] = switch_q[k-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) data_q[k] <= 8'd0;
        valid_q  <= '0;
        switch_q <= '0;
      end else begin
        for (int k = 0; k <= r; k++) data_q[k] <= data_d[k];
        valid_q  <= valid_d;
        switch_q <= switch_d;
      end
    end

    assign out_input[8*r +: 8] = data_q[r];
    assign out_valid[r]        = valid_q[r];
    assign out_switch[r]       = switch_q[r];
  end

endmodule

// File: tb/tb_sa_input_skew.sv
// tb/tb_sa_input_skew.sv - scoreboard bench for sa_input_skew
// Stimulus pushes expected per-row beats and tile results; a negedge monitor pops and compares.
module tb_sa_input_skew;

  localparam int ROWS  = 4;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ROWS*8-1:0] in_data;
  logic              in_switch;
  logic              in_last;
  logic [ROWS*8-1:0] out_input;
  logic [ROWS-1:0]   out_valid;
  logic [ROWS-1:0]   out_switch;
  logic              tile_done;
  logic [CNT_W-1:0]  tile_len;

  sa_input_skew #(.ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_switch  (in_switch),
    .in_last    (in_last),
    .out_input  (out_input),
    .out_valid  (out_valid),
    .out_switch (out_switch),
    .tile_done  (tile_done),
    .tile_len   (tile_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       sw;
  } beat_t;

  typedef struct {
    int cyc;
    int len;
  } tile_t;

  beat_t rq [ROWS][$];
  tile_t tq [$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  beat_t mon_b;
  tile_t mon_t;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int idx, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] at cyc %0d: got %0h want %0h", name, idx, cyc, got, want);
    end
  endtask

  // Called just after a rising edge: drive one cycle of inputs; the next edge is the accept edge.
  task automatic drive(input logic v, input logic [ROWS*8-1:0] d, input logic sw, input logic last,
                       input logic exp_rdy, input int len);
    int e;
    in_valid  = v;
    in_data   = d;
    in_switch = sw;
    in_last   = last;
    chk("in_ready", cyc, in_ready, exp_rdy);
    e = cyc + 1;
    if (v && exp_rdy) begin
      for (int r = 0; r < ROWS; r++) rq[r].push_back('{e + r, d[8*r +: 8], sw});
      if (last) tq.push_back('{e + ROWS - 1, len});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic exp_rdy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, exp_rdy, 0);
  endtask

  always @(negedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (out_valid[r]) begin
        if (rq[r].size() == 0) begin
          chk("row_unexpected_valid", r, 1, 0);
        end else begin
          mon_b = rq[r].pop_front();
          chk("row_cycle", r, 64'(cyc), 64'(mon_b.cyc));
          chk("row_data", r, out_input[8*r +: 8], mon_b.data);
          chk("row_switch", r, out_switch[r], mon_b.sw);
        end
      end else begin
        chk("bubble_data", r, out_input[8*r +: 8], 8'd0);
        chk("bubble_switch", r, out_switch[r], 1'b0);
      end
    end
    if (tile_done) begin
      if (tq.size() == 0) begin
        chk("tile_done_unexpected", 0, 1, 0);
      end else begin
        mon_t = tq.pop_front();
        chk("tile_done_cycle", 0, 64'(cyc), 64'(mon_t.cyc));
        chk("tile_len", 0, 64'(tile_len), 64'(mon_t.len));
      end
    end
  end

  task automatic chk_reset_outputs(input int tag);
    chk("rst_out_input", tag, out_input, '0);
    chk("rst_out_valid", tag, out_valid, '0);
    chk("rst_out_switch", tag, out_switch, '0);
    chk("rst_tile_done", tag, tile_done, 1'b0);
    chk("rst_tile_len", tag, tile_len, '0);
    chk("rst_in_ready", tag, in_ready, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_switch = 1'b0; in_last = 1'b0;
    #1;
    chk_reset_outputs(0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_reset", 0, in_ready, 1'b1);
    idle(2, 1'b1);

    // Single-beat tile: row r shows r+1.
    drive(1'b1, 32'h04030201, 1'b0, 1'b1, 1'b1, 1);
    idle(4, 1'b0);
    idle(1, 1'b1);

    // Three back-to-back beats including the most negative value.
    drive(1'b1, 32'h01010101, 1'b0, 1'b0, 1'b1, 0);
    drive(1'b1, 32'h02020202, 1'b0, 1'b0, 1'b1, 0);
    drive(1'b1, 32'h80808080, 1'b0, 1'b1, 1'b1, 3);
    idle(4, 1'b0);

    // Weight switch on the second beat only.
    drive(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 0);
    drive(1'b1, 32'h22222222, 1'b1, 1'b0, 1'b1, 0);
    drive(1'b1, 32'h33333333, 1'b0, 1'b1, 1'b1, 3);
    idle(4, 1'b0);

    // Producer holds valid through the drain; held vector opens the next tile.
    drive(1'b1, 32'h0a0b0c0d, 1'b0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h05060708, 1'b0, 1'b1, 1'b0, 0);
    drive(1'b1, 32'h05060708, 1'b0, 1'b1, 1'b1, 1);
    idle(4, 1'b0);

    // Two-cycle gap inside a tile.
    drive(1'b1, 32'h0f0e0d0c, 1'b0, 1'b0, 1'b1, 0);
    idle(2, 1'b1);
    drive(1'b1, 32'hffffffff, 1'b1, 1'b1, 1'b1, 2);
    idle(4, 1'b0);

    // Reset mid-stream discards in-flight beats with no tile_done.
    drive(1'b1, 32'h01020304, 1'b0, 1'b0, 1'b1, 0);
    drive(1'b1, 32'h05060708, 1'b0, 1'b0, 1'b1, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    for (int r = 0; r < ROWS; r++) rq[r].delete();
    tq.delete();
    #1;
    chk_reset_outputs(1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ready_after_midreset", 1, in_ready, 1'b1);
    idle(6, 1'b1);

    // Beat counter restarts from zero after reset.
    drive(1'b1, 32'h7f017f01, 1'b0, 1'b1, 1'b1, 1);
    idle(4, 1'b0);
    idle(2, 1'b1);

    for (int r = 0; r < ROWS; r++) chk("row_queue_empty", r, 64'(rq[r].size()), 0);
    chk("tile_queue_empty", 0, 64'(tq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
